cnn_frame_loader: RTL and testbench
===================================

Name: cnn_frame_loader

Overview:
Stage directly upstream of cnn_top. Accepts a pixel stream over a valid/ready handshake and assembles one full image (IMG_SIZE words) in a local buffer. Presents the image in parallel to cnn_top, holds enable high until the core reports done, then captures the prediction and offers it downstream on a valid/ready result port. Also bounds core run time with a timeout.

Parameters:
IMG_SIZE, 64, words per image; must match the cnn_top input_img depth.
DATA_W, 32, pixel word width.
OUT_W, 32, prediction width; must match the cnn_top value width.
TIMEOUT, 1000, maximum RUN-state cycles before abort; must be at least 1.

Ports:
clk  in  1  single clock, rising edge.
rst  in  1  asynchronous, active-low reset (0 = reset).
s_data  in  DATA_W  pixel word.
s_valid  in  1  pixel word valid.
s_last  in  1  marks the final word of a frame.
s_ready  out  1  loader can accept a word.
img_flat  out  IMG_SIZE*DATA_W  image buffer; word i sits at bits [i*DATA_W +: DATA_W]; drives cnn_top input_img.
core_enable  out  1  drives cnn_top enable.
core_value  in  OUT_W  cnn_top value.
core_done  in  1  cnn_top done.
res_data  out  OUT_W  captured prediction.
res_valid  out  1  prediction available.
res_ready  in  1  downstream accepts the prediction.
frame_err  out  1  one-cycle pulse on a malformed frame.
timeout  out  1  one-cycle pulse on a core timeout.
busy  out  1  high in RUN and HOLD.

Behaviour:
- Reset (rst=0, asynchronous):
  - State goes to LOAD; write pointer is 0; timeout counter is 0.
  - All buffer words are 0.
  - Outputs: s_ready=0 while rst=0, then 1 from the first cycle after release. core_enable=0, res_data=0, res_valid=0, frame_err=0, timeout=0, busy=0.
  - Reset asserted in any state aborts the frame or result in flight.
- States: LOAD, RUN, HOLD.
- LOAD:
  - s_ready=1.
  - On s_valid&&s_ready, write s_data to buffer[wr_ptr].
  - If wr_ptr==IMG_SIZE-1 and s_last=1: next state RUN, wr_ptr returns to 0.
  - If wr_ptr<IMG_SIZE-1 and s_last=1: short frame. Pulse frame_err, set wr_ptr=0, stay in LOAD.
  - If wr_ptr==IMG_SIZE-1 and s_last=0: long frame. Pulse frame_err, set wr_ptr=0, stay in LOAD. Later words up to s_last start a new frame attempt.
  - Buffer words from an aborted frame are overwritten by the next frame; they are not cleared.
- RUN:
  - s_ready=0, core_enable=1, busy=1. The buffer is frozen.
  - core_enable first rises in the cycle after the final beat is accepted.
  - On core_done==1: register core_value into res_data, set res_valid=1, core_enable=0, next state HOLD.
  - Timeout counter increments each RUN cycle. If it reaches TIMEOUT before done: pulse timeout, core_enable=0, counter to 0, next state LOAD; no result is produced.
  - If done and the timeout count arrive in the same cycle, done wins.
- HOLD:
  - res_valid=1, res_data stable, s_ready=0, busy=1, core_enable=0.
  - On res_valid&&res_ready: res_valid=0, next state LOAD, counter to 0.
  - A core_done still high in HOLD is ignored.
- Latency: res_valid rises exactly 1 cycle after the first cycle core_done=1 is sampled in RUN.
- Throughput: ingest of the next frame begins the cycle after the result handshake; there is no overlap of load and run.
- Width rules: wr_ptr is $clog2(IMG_SIZE) bits; the timeout counter is $clog2(TIMEOUT+1) bits; no arithmetic on data.

Decomposition:
- Shared package cnn_pkg holds:
  - state encodings LOAD=2'd0, RUN=2'd1, HOLD=2'd2;
  - IMG_SIZE, DATA_W and OUT_W defaults, shared with cnn_top.
- One natural sub-module, cnn_frame_buffer: an IMG_SIZE x DATA_W register array with write enable and index, plus a flattened read-out. The FSM, counters and handshakes stay in cnn_frame_loader.

Test Plan:
1. Stream 64 words of 1 with s_last on beat 63; the core model raises done 5 cycles after enable with value=42. Required: core_enable rises the cycle after beat 63; res_valid=1 and res_data=42 one cycle after done; res_ready=1 returns the block to LOAD with s_ready=1.
2. Stream words i (0..63), toggling s_valid randomly. Required: img_flat word i == i for all i; no frame_err.
3. Assert s_last on beat 10. Required: frame_err pulses once; the next full 64-beat frame (value 7) loads cleanly and the core sees all 7s.
4. Core model never raises done. Required: after exactly 1000 RUN cycles, timeout pulses, core_enable=0, s_ready=1, res_valid stays 0.
5. Hold res_ready=0 for 20 cycles after a result of 99. Required: res_valid stays 1, res_data stays 99, s_ready stays 0 throughout; core_done pulses in HOLD are ignored.
6. Drive rst=0 mid-RUN (cycle 3). Required: core_enable, res_valid and busy drop to 0 immediately without waiting for a clock edge; after release the block accepts a fresh 64-word frame.

Source files
------------

// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN front-end: state encodings and the
// image/data geometry that cnn_top is built around.
package cnn_pkg;

   typedef enum logic [1:0] {
      LOAD = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2
   } state_t;

   localparam int CNN_IMG_SIZE = 64;
   localparam int CNN_DATA_W   = 32;
   localparam int CNN_OUT_W    = 32;

endpackage

// File: rtl/cnn_frame_loader_if.sv
// Single-beat-per-cycle stream bundle.
// Handshake: a beat transfers on a rising clock edge where valid && ready
// are both high; the master holds data/last stable while valid is high and
// ready is low, and ready may not depend combinationally on valid.
interface cnn_stream_if #(
   parameter int W = 32
) ();
   logic [W-1:0] data;
   logic         valid;
   logic         last;
   logic         ready;

   modport master (output data, output valid, output last, input ready);
   modport slave  (input data, input valid, input last, output ready);
endinterface

// File: rtl/cnn_frame_buffer.sv
// IMG_SIZE x DATA_W image store with one indexed write port and the whole
// contents presented flattened, word i at bits [i*DATA_W +: DATA_W].
module cnn_frame_buffer
   import cnn_pkg::*;
#(
   parameter int IMG_SIZE = CNN_IMG_SIZE,
   parameter int DATA_W   = CNN_DATA_W,
   localparam int PTR_W   = $clog2(IMG_SIZE)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       we,
   input  logic [PTR_W-1:0]           idx,
   input  logic [DATA_W-1:0]          wdata,
   output logic [IMG_SIZE*DATA_W-1:0] flat
);

   logic [DATA_W-1:0] mem_q [IMG_SIZE];

   // Word storage: cleared on reset, otherwise written one word per beat.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < IMG_SIZE; i++) begin
            mem_q[i] <= '0;
         end
      end else if (we) begin
         mem_q[idx] <= wdata;
      end
   end

   for (genvar g = 0; g < IMG_SIZE; g++) begin : g_flat
      assign flat[g*DATA_W +: DATA_W] = mem_q[g];
   end

endmodule

// File: rtl/cnn_frame_loader.sv
// Front-end for cnn_top: gathers one image from a pixel stream, runs the
// core on it with a cycle budget, and parks the prediction on a result port
// until it is taken. Load and run never overlap.
module cnn_frame_loader
   import cnn_pkg::*;
#(
   parameter int IMG_SIZE = CNN_IMG_SIZE,
   parameter int DATA_W   = CNN_DATA_W,
   parameter int OUT_W    = CNN_OUT_W,
   parameter int TIMEOUT  = 1000
) (
   input  logic                       clk,
   input  logic                       rst,
   cnn_stream_if.slave                pix,
   cnn_stream_if.master               res,
   output logic [IMG_SIZE*DATA_W-1:0] img_flat,
   output logic                       core_enable,
   input  logic [OUT_W-1:0]           core_value,
   input  logic                       core_done,
   output logic                       frame_err,
   output logic                       timeout,
   output logic                       busy,
   output logic [1:0]                 state_o
);

   localparam int PTR_W = $clog2(IMG_SIZE);
   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(IMG_SIZE - 1);
   localparam logic [CNT_W-1:0] TO_CNT   = CNT_W'(TIMEOUT);

   state_t             state_q, state_d;
   logic [PTR_W-1:0]   ptr_q, ptr_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
   logic [OUT_W-1:0]   res_data_q, res_data_d;
   logic               ferr_q, ferr_d;
   logic               tout_q, tout_d;
   logic               init_q;
   logic               s_ready;
   logic               pix_fire;

   // s_ready stays low until the first clock after reset is released.
   assign s_ready  = init_q && (state_q == LOAD);
   assign pix_fire = pix.valid && s_ready;
   assign cnt_inc  = cnt_q + 1'b1;

   assign pix.ready   = s_ready;
   assign res.valid   = (state_q == HOLD);
   assign res.data    = res_data_q;
   assign res.last    = 1'b1;
   assign core_enable = (state_q == RUN);
   assign busy        = (state_q == RUN) || (state_q == HOLD);
   assign frame_err   = ferr_q;
   assign timeout     = tout_q;
   assign state_o     = state_q;

   cnn_frame_buffer #(
      .IMG_SIZE (IMG_SIZE),
      .DATA_W   (DATA_W)
   ) u_buf (
      .clk   (clk),
      .rst   (rst),
      .we    (pix_fire),
      .idx   (ptr_q),
      .wdata (pix.data),
      .flat  (img_flat)
   );

   // Marks the end of reset so the stream port opens one cycle after release.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) init_q <= 1'b0;
      else      init_q <= 1'b1;
   end

   // State, pointer, run counter, captured result and event pulses.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= LOAD;
         ptr_q      <= '0;
         cnt_q      <= '0;
         res_data_q <= '0;
         ferr_q     <= 1'b0;
         tout_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         ptr_q      <= ptr_d;
         cnt_q      <= cnt_d;
         res_data_q <= res_data_d;
         ferr_q     <= ferr_d;
         tout_q     <= tout_d;
      end
   end

   // Next-state logic: frame assembly, core supervision, result hand-off.
   always_comb begin
      state_d    = state_q;
      ptr_d      = ptr_q;
      cnt_d      = cnt_q;
      res_data_d = res_data_q;
      ferr_d     = 1'b0;
      tout_d     = 1'b0;
      unique case (state_q)
         LOAD: begin
            cnt_d = '0;
            if (pix_fire) begin
               if (pix.last) begin
                  ptr_d = '0;
                  if (ptr_q == LAST_PTR) state_d = RUN;
                  else                   ferr_d  = 1'b1;
               end else if (ptr_q == LAST_PTR) begin
                  // Overlong frame: drop it; following words begin a new attempt.
                  ptr_d  = '0;
                  ferr_d = 1'b1;
               end else begin
                  ptr_d = ptr_q + 1'b1;
               end
            end
         end
         RUN: begin
            // done is checked first so it beats a simultaneous budget expiry.
            if (core_done) begin
               res_data_d = core_value;
               cnt_d      = '0;
               state_d    = HOLD;
            end else if (cnt_inc == TO_CNT) begin
               tout_d  = 1'b1;
               cnt_d   = '0;
               state_d = LOAD;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         HOLD: begin
            if (res.ready) begin
               cnt_d   = '0;
               state_d = LOAD;
            end
         end
         default: state_d = LOAD;
      endcase
   end

endmodule

// File: tb/tb_cnn_frame_loader.sv
// Directed bench for cnn_frame_loader with a small behavioural core model.
module tb_cnn_frame_loader;

   localparam int IMG   = 64;
   localparam int DW    = 32;
   localparam int OW    = 32;
   localparam int TO    = 1000;
   localparam int FLATW = IMG * DW;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   cnn_stream_if #(.W(DW)) pix ();
   cnn_stream_if #(.W(OW)) res ();

   logic [FLATW-1:0] img_flat;
   logic             core_enable;
   logic [OW-1:0]    core_value;
   logic             core_done;
   logic             frame_err;
   logic             timeout;
   logic             busy;
   logic [1:0]       state_o;

   cnn_frame_loader #(
      .IMG_SIZE (IMG),
      .DATA_W   (DW),
      .OUT_W    (OW),
      .TIMEOUT  (TO)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .pix         (pix),
      .res         (res),
      .img_flat    (img_flat),
      .core_enable (core_enable),
      .core_value  (core_value),
      .core_done   (core_done),
      .frame_err   (frame_err),
      .timeout     (timeout),
      .busy        (busy),
      .state_o     (state_o)
   );

   // Core model: done pulses core_delay cycles after enable rises.
   logic          core_on    = 1'b0;
   int            core_delay = 5;
   logic [OW-1:0] core_val   = '0;
   logic          done_model = 1'b0;
   logic          force_done = 1'b0;
   int            en_cnt     = 0;

   always @(posedge clk) begin
      if (core_enable) begin
         en_cnt     <= en_cnt + 1;
         done_model <= core_on && (en_cnt + 1 == core_delay);
      end else begin
         en_cnt     <= 0;
         done_model <= 1'b0;
      end
   end
   assign core_done  = done_model | force_done;
   assign core_value = core_val;

   // Pulse counters.
   int ferr_cnt = 0;
   int tout_cnt = 0;
   always @(posedge clk) begin
      if (frame_err) ferr_cnt++;
      if (timeout)   tout_cnt++;
   end

   int total  = 0;
   int passed = 0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   task automatic check_flat(input string tag, input logic [31:0] base, input bit incr);
      logic [FLATW-1:0] exp_flat;
      int bad;
      bad = 0;
      for (int i = 0; i < IMG; i++) begin
         exp_flat[i*DW +: DW] = incr ? 32'(i) : base;
         if (img_flat[i*DW +: DW] !== exp_flat[i*DW +: DW]) bad++;
      end
      total++;
      assert (img_flat === exp_flat) passed++;
      else $error("FAIL %s observed=%0d bad words, word0=%0h expected word0=%0h",
                  tag, bad, img_flat[DW-1:0], exp_flat[DW-1:0]);
   endtask

   task automatic send_beat(input logic [31:0] d, input bit last);
      int n;
      n = 0;
      pix.data  = d;
      pix.last  = last;
      pix.valid = 1'b1;
      while (!pix.ready && n < 2000) begin
         tick();
         n++;
      end
      if (!pix.ready) check("beat_ready_wait", 64'(pix.ready), 64'd1);
      tick();
      pix.valid = 1'b0;
      pix.last  = 1'b0;
   endtask

   task automatic send_frame(input logic [31:0] v, input int n, input bit last_at_end,
                             input bit gaps, input bit incr);
      for (int i = 0; i < n; i++) begin
         if (gaps) repeat ($urandom_range(0, 2)) tick();
         send_beat(incr ? 32'(i) : v, last_at_end && (i == n - 1));
      end
   endtask

   task automatic take_result(input string tag, input logic [31:0] exp_val);
      int n;
      n = 0;
      while (!res.valid && n < 200) begin
         tick();
         n++;
      end
      check({tag, "_res_valid"}, 64'(res.valid), 64'd1);
      check({tag, "_res_data"}, 64'(res.data), 64'(exp_val));
      res.ready = 1'b1;
      tick();
      res.ready = 1'b0;
      check({tag, "_back_to_load"}, 64'({pix.ready, res.valid, busy}), 64'b100);
   endtask

   initial begin
      int n;
      bit seen;
      pix.data   = '0;
      pix.valid  = 1'b0;
      pix.last   = 1'b0;
      res.ready  = 1'b0;

      // Reset state.
      repeat (3) tick();
      check("rst_s_ready", 64'(pix.ready), 64'd0);
      check("rst_outputs", 64'({core_enable, res.valid, frame_err, timeout, busy}), 64'd0);
      check("rst_res_data", 64'(res.data), 64'd0);
      check("rst_state", 64'(state_o), 64'd0);
      check_flat("rst_flat", 32'd0, 1'b0);
      rst = 1'b1;
      check("rel_s_ready_low", 64'(pix.ready), 64'd0);
      tick();
      check("rel_s_ready_high", 64'(pix.ready), 64'd1);

      // 1: frame of ones, result 42 after 5 cycles.
      core_on = 1'b1; core_delay = 5; core_val = 32'd42;
      send_frame(32'd1, IMG - 1, 1'b0, 1'b0, 1'b0);
      check("t1_enable_before_last", 64'(core_enable), 64'd0);
      send_beat(32'd1, 1'b1);
      check("t1_enable_after_last", 64'({core_enable, busy, pix.ready}), 64'b110);
      check_flat("t1_flat", 32'd1, 1'b0);
      n = 0;
      while (!core_done && n < 50) begin tick(); n++; end
      check("t1_done_seen", 64'(core_done), 64'd1);
      check("t1_res_valid_not_yet", 64'(res.valid), 64'd0);
      tick();
      check("t1_res_valid_latency", 64'(res.valid), 64'd1);
      check("t1_res_data", 64'(res.data), 64'd42);
      check("t1_enable_off", 64'(core_enable), 64'd0);
      take_result("t1", 32'd42);

      // 2: incrementing words with random valid gaps.
      core_delay = 3; core_val = 32'd5;
      send_frame(32'd0, IMG, 1'b1, 1'b1, 1'b1);
      check("t2_enable", 64'(core_enable), 64'd1);
      check_flat("t2_flat", 32'd0, 1'b1);
      check("t2_no_frame_err", 64'(ferr_cnt), 64'd0);
      take_result("t2", 32'd5);

      // 3: short frame, then a clean frame of sevens.
      core_val = 32'd7;
      send_frame(32'd3, 11, 1'b1, 1'b0, 1'b0);
      check("t3_short_pulse_now", 64'(frame_err), 64'd1);
      tick();
      check("t3_short_err_once", 64'(ferr_cnt), 64'd1);
      check("t3_short_in_load", 64'({pix.ready, core_enable, frame_err}), 64'b100);
      send_frame(32'd7, IMG, 1'b1, 1'b0, 1'b0);
      check("t3_enable", 64'(core_enable), 64'd1);
      check_flat("t3_flat_sevens", 32'd7, 1'b0);
      check("t3_err_count", 64'(ferr_cnt), 64'd1);
      take_result("t3", 32'd7);

      // 3b: overlong frame (no last by word 63) is dropped.
      send_frame(32'd2, IMG, 1'b0, 1'b0, 1'b0);
      tick();
      check("t3b_long_err", 64'(ferr_cnt), 64'd2);
      check("t3b_still_load", 64'({pix.ready, core_enable}), 64'b10);

      // 4: core never finishes.
      core_on = 1'b0;
      send_frame(32'd9, IMG, 1'b1, 1'b0, 1'b0);
      seen = 1'b0;
      repeat (TO - 1) begin
         tick();
         seen |= res.valid | timeout;
      end
      check("t4_no_early_abort", 64'({seen, core_enable}), 64'b01);
      tick();
      check("t4_timeout_pulse", 64'(timeout), 64'd1);
      check("t4_after_abort", 64'({core_enable, pix.ready, res.valid, busy}), 64'b0100);
      tick();
      check("t4_timeout_once", 64'({timeout, 8'(tout_cnt)}), 64'({1'b0, 8'd1}));

      // 5: result held under backpressure; stray done ignored.
      core_on = 1'b1; core_delay = 2; core_val = 32'd99;
      send_frame(32'd4, IMG, 1'b1, 1'b0, 1'b0);
      n = 0;
      while (!res.valid && n < 50) begin tick(); n++; end
      for (int c = 0; c < 20; c++) begin
         force_done = (c == 5) || (c == 12);
         tick();
         check("t5_hold_flags", 64'({res.valid, pix.ready, core_enable, busy}), 64'b1001);
         check("t5_hold_data", 64'(res.data), 64'd99);
      end
      force_done = 1'b0;
      take_result("t5", 32'd99);

      // 6: asynchronous reset in RUN.
      core_on = 1'b0;
      send_frame(32'd6, IMG, 1'b1, 1'b0, 1'b0);
      tick();
      tick();
      check("t6_in_run", 64'(core_enable), 64'd1);
      #2 rst = 1'b0;
      #1;
      check("t6_async_drop", 64'({core_enable, res.valid, busy, pix.ready}), 64'd0);
      check("t6_state_load", 64'(state_o), 64'd0);
      check_flat("t6_flat_cleared", 32'd0, 1'b0);
      #3 rst = 1'b1;
      tick();
      check("t6_ready_after_rel", 64'(pix.ready), 64'd1);
      core_on = 1'b1; core_delay = 4; core_val = 32'h77;
      send_frame(32'd11, IMG, 1'b1, 1'b0, 1'b0);
      check_flat("t6_fresh_flat", 32'd11, 1'b0);
      take_result("t6", 32'h77);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
